uart_imem_loader: RTL and testbench
===================================

# uart_imem_loader

Serial program loader for the monocycle RISC-V core. It receives a framed program image over an 8N1 UART line and assembles bytes into 32-bit little-endian words. It writes those words sequentially into instruction memory from byte address 0, holding the core in reset until the image is complete. It is the write side of the instruction-memory interface the core fetches from; the top level ORs `cpu_hold` into the core's reset and muxes the imem write port.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- `DEPTH_WORDS`, 256, instruction-memory capacity in 32-bit words.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high; restarts loader and re-asserts `cpu_hold`.
- `rx` input 1: asynchronous UART line, idle high.
- `imem_we` output 1: one-cycle write strobe.
- `imem_addr` output 32: byte address of write, word-aligned.
- `imem_wdata` output 32: word to write.
- `cpu_hold` output 1: high while loading; core must be held in reset.
- `done` output 1: image fully written; sticky until `reset`.
- `error` output 1: framing or length error; sticky until `reset`.
- `word_count` output 16: number of words written so far.

## Operation
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `word_count`=0; both FSMs idle.
- `rx` passes through a 2-flop synchronizer. All sampling uses the synchronized signal.
- RX FSM states and transitions:
  - RX_IDLE to RX_START on synchronized low.
  - RX_START waits CLKS_PER_BIT/2 and re-samples. Low goes to RX_DATA. High is a glitch and returns to RX_IDLE with no error.
  - RX_DATA samples 8 bits, LSB first, each CLKS_PER_BIT apart.
  - RX_STOP samples one CLKS_PER_BIT later. High emits `byte_valid` for one cycle. Low raises a framing error.
  - The RX FSM returns to RX_IDLE in the cycle after the stop sample; it does not wait the rest of the stop bit.
- Frame format:
  - Sync byte 0xA5.
  - Word count N, 16-bit little-endian (low byte first).
  - N×4 data bytes, each word little-endian (first byte goes to bits [7:0]).
- Frame FSM states:
  - WAIT_SYNC: bytes other than 0xA5 are ignored; 0xA5 goes to LEN_LO.
  - LEN_LO, then LEN_HI.
  - After LEN_HI: N=0 goes to DONE; N>DEPTH_WORDS goes to ERROR; otherwise DATA.
  - DATA: a 2-bit byte index assembles a 32-bit word. On the 4th byte, `imem_we` pulses the next cycle with `imem_addr`=`word_count`×4. `word_count` increments in the same cycle as the strobe.
  - After the Nth word's strobe, the FSM goes to DONE.
  - DONE: `done`=1, `cpu_hold`=0; all further bytes ignored.
  - ERROR: `error`=1, `cpu_hold` stays 1, `imem_we` never asserts; all further bytes ignored.
- A framing error in any state except DONE goes to ERROR.
- `imem_addr`/`imem_wdata` hold their last written values between strobes.

## Timing
- Stop-bit sample to `byte_valid`: 0 cycles (same cycle the stop sample completes).
- `byte_valid` of the 4th data byte to `imem_we`: 1 cycle. `imem_we` high exactly 1 cycle.
- Last `imem_we` to `done`=1 and `cpu_hold`=0: 1 cycle.
- LEN_HI byte to `done` (N=0) or `error` (N too large): 1 cycle.
- Pin to internal edge detect: 2 cycles of synchronizer delay; the sample point is offset accordingly but stays within ±1 cycle of bit center.
- `reset` mid-byte or mid-frame: next cycle all outputs return to reset values, and the partial word is discarded. A byte in flight on the line is not recovered; the host must resend the whole frame.
- Word index arithmetic is 16-bit. `imem_addr` = {14'b0, word_count, 2'b00}; no wrap is possible because N≤DEPTH_WORDS.

## Test plan
- Nominal load, CLKS_PER_BIT=16: send A5 02 00 13 05 A0 00 93 05 10 00. Expect `imem_we` pulses with (addr 0x0, data 0x00A00513) and (addr 0x4, data 0x00100593), then `done`=1, `cpu_hold`=0, `word_count`=2.
- Junk before sync: send 00 FF 5A, then A5 01 00 EF BE AD DE. Expect exactly one write, addr 0, data 0xDEADBEEF; no `error`.
- Length overflow, DEPTH_WORDS=256: send A5 01 01 (N=257). Expect `error`=1 one cycle after the 3rd byte, zero `imem_we` pulses, `cpu_hold`=1.
- Framing error: drive the stop bit low on the 5th byte of a valid frame. Expect `error`=1, no further writes, `done`=0.
- Start-bit glitch: low pulse of 3 cycles on idle `rx`. Expect no `byte_valid`, FSM still in WAIT_SYNC, and a following full frame loads correctly.
- Reset mid-word: assert `reset` for 1 cycle after 2 data bytes of word 1, then resend the full frame A5 01 00 78 56 34 12. Expect all outputs at reset values, then a single write of 0x12345678 at addr 0, then `done`=1.

Source files
------------

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
// Kept free of clocks so it can be muxed straight onto the imem write port.
interface uart_imem_loader_if;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_imem_loader.sv
// 8N1 UART receiver plus frame parser that streams a little-endian program
// image into instruction memory while holding the core in reset.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_WORDS  = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  uart_imem_loader_if.master         bus,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       error,
  output logic [15:0]                word_count
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    F_WAIT_SYNC, F_LEN_LO, F_LEN_HI, F_DATA, F_WRITE, F_DONE, F_ERROR
  } frame_state_t;

  logic          rx_meta, rx_sync;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          rx_tick, byte_valid, frame_err;

  frame_state_t  f_state, f_next;
  logic [15:0]   len;
  logic [15:0]   len_word;
  logic [1:0]    byte_idx;
  logic [31:0]   word_buf;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- RX FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      clk_cnt  <= (rx_state == RX_IDLE || rx_tick) ? '0 : clk_cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statements can infer a latch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Start bit is re-sampled at half a bit; the synchronizer delay is
  // absorbed in the -1 and keeps later samples near bit centre.
  always_comb begin
    rx_tick = 1'b0;
    case (rx_state)
      RX_START:         rx_tick = (clk_cnt == CW'(HALF - 1));
      RX_DATA, RX_STOP: rx_tick = (clk_cnt == CW'(CLKS_PER_BIT - 1));
      default:          rx_tick = 1'b0;
    endcase
    byte_valid = (rx_state == RX_STOP) && rx_tick && rx_sync;
    frame_err  = (rx_state == RX_STOP) && rx_tick && !rx_sync;
  end

  // ---------------- Frame FSM ----------------
  assign len_word = {rx_shift, len[7:0]};

  always_ff @(posedge clk) begin
    if (reset) f_state <= F_WAIT_SYNC;
    else       f_state <= f_next;
  end

  always_comb begin
    f_next = f_state;
    if (frame_err && f_state != F_DONE) begin
      f_next = F_ERROR;
    end else begin
      case (f_state)
        F_WAIT_SYNC: if (byte_valid && rx_shift == 8'hA5) f_next = F_LEN_LO;
        F_LEN_LO:    if (byte_valid) f_next = F_LEN_HI;
        F_LEN_HI: begin
          if (byte_valid) begin
            if (len_word == 16'd0)                   f_next = F_DONE;
            else if (int'(len_word) > DEPTH_WORDS)   f_next = F_ERROR;
            else                                     f_next = F_DATA;
          end
        end
        F_DATA:      if (byte_valid && byte_idx == 2'd3) f_next = F_WRITE;
        // word_count has already advanced when this state is reached.
        F_WRITE:     f_next = (word_count == len) ? F_DONE : F_DATA;
        default:     f_next = f_state;
      endcase
    end
  end

  always_comb begin
    bus.imem_we = (f_state == F_WRITE);
    done        = (f_state == F_DONE);
    error       = (f_state == F_ERROR);
    cpu_hold    = (f_state != F_DONE);
  end

  // Bytes shift in from the top so the first byte lands in bits [7:0].
  always_ff @(posedge clk) begin
    if (reset) begin
      len            <= '0;
      byte_idx       <= '0;
      word_buf       <= '0;
      word_count     <= '0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else if (byte_valid) begin
      case (f_state)
        F_LEN_LO: len[7:0] <= rx_shift;
        F_LEN_HI: begin
          len[15:8] <= rx_shift;
          byte_idx  <= '0;
        end
        F_DATA: begin
          byte_idx <= byte_idx + 1'b1;
          word_buf <= {rx_shift, word_buf[31:8]};
          if (byte_idx == 2'd3) begin
            bus.imem_wdata <= {rx_shift, word_buf[31:8]};
            bus.imem_addr  <= {14'b0, word_count, 2'b00};
            word_count     <= word_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed frame table, multi-cycle
// corner sequences and randomized frames scored against a frame-level model.
module tb_uart_imem_loader;

  localparam int CPB   = 16;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        cpu_hold, done, error;
  logic [15:0] word_count;

  uart_imem_loader_if bus ();

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int   last_we_cyc, done_cyc, err_cyc, we_long;
  logic prev_we, prev_done, prev_err;

  always @(negedge clk) begin
    if (reset) begin
      wr_addr_q.delete();
      wr_data_q.delete();
      we_long     <= 0;
      last_we_cyc <= -1;
      done_cyc    <= -1;
      err_cyc     <= -1;
      prev_we     <= 1'b0;
      prev_done   <= 1'b0;
      prev_err    <= 1'b0;
    end else begin
      if (bus.imem_we) begin
        wr_addr_q.push_back(bus.imem_addr);
        wr_data_q.push_back(bus.imem_wdata);
        last_we_cyc <= cyc;
        if (prev_we) we_long <= we_long + 1;
      end
      if (done && !prev_done) done_cyc <= cyc;
      if (error && !prev_err) err_cyc <= cyc;
      prev_we   <= bus.imem_we;
      prev_done <= done;
      prev_err  <= error;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] tx_b[$];
  bit         tx_bad[$];
  int         stop_cyc;

  task automatic pulse_reset();
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " addr/wdata"}, {bus.imem_addr, bus.imem_wdata}, 64'h0);
    check({tag, " we/hold/done/err/count"},
          64'({bus.imem_we, cpu_hold, done, error, word_count}),
          64'({1'b0, 1'b1, 1'b0, 1'b0, 16'h0}));
  endtask

  // Entered and left on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = !bad_stop;
    stop_cyc = cyc;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit do_reset);
    if (do_reset) begin
      pulse_reset();
      check_reset_outputs("reset state");
    end
    foreach (tx_b[i]) send_byte(tx_b[i], tx_bad[i]);
    repeat (4 * CPB) @(negedge clk);
  endtask

  task automatic load_bytes(input logic [127:0] p, input int n, input int bad_idx);
    tx_b.delete();
    tx_bad.delete();
    for (int i = 0; i < n; i++) begin
      tx_b.push_back(p[8*(n-1-i) +: 8]);
      tx_bad.push_back(i == bad_idx);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  bit          exp_done, exp_err;

  task automatic run_model();
    int phase = 0;
    int n = 0;
    int k = 0;
    logic [31:0] w = '0;
    bit fin = 1'b0;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    foreach (tx_b[i]) begin
      if (fin) continue;
      if (tx_bad[i]) begin
        exp_err = 1'b1;
        fin = 1'b1;
        continue;
      end
      case (phase)
        0: if (tx_b[i] == 8'hA5) phase = 1;
        1: begin n = int'(tx_b[i]); phase = 2; end
        2: begin
          n += int'(tx_b[i]) * 256;
          if (n == 0)          begin exp_done = 1'b1; fin = 1'b1; end
          else if (n > DEPTH)  begin exp_err = 1'b1; fin = 1'b1; end
          else phase = 3;
        end
        default: begin
          w = w | (32'(tx_b[i]) << (8 * (k % 4)));
          k++;
          if (k % 4 == 0) begin
            exp_q.push_back(w);
            w = '0;
            if (exp_q.size() == n) begin exp_done = 1'b1; fin = 1'b1; end
          end
        end
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    run_model();
    check({tag, " write count"}, 64'(wr_data_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), 64'(wr_addr_q[i]), 64'(32'(i * 4)));
      check($sformatf("%s data[%0d]", tag, i), 64'(wr_data_q[i]), 64'(exp_q[i]));
    end
    check({tag, " done"}, 64'(done), 64'(exp_done));
    check({tag, " error"}, 64'(error), 64'(exp_err));
    check({tag, " cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
    check({tag, " word_count"}, 64'(word_count), 64'(exp_q.size()));
    check({tag, " strobe width"}, 64'(we_long), 64'(0));
    if (exp_done && exp_q.size() > 0)
      check({tag, " done latency"}, 64'(done_cyc - last_we_cyc), 64'(1));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string        name;
    logic [127:0] bytes;
    int           nbytes;
    int           bad_idx;
    int           exp_writes;
    logic [31:0]  exp_last_addr;
    logic [31:0]  exp_last_data;
    bit           exp_done;
    bit           exp_error;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"nominal", 128'hA5_02_00_13_05_A0_00_93_05_10_00, 11, -1,
                2, 32'h4, 32'h00100593, 1'b1, 1'b0};
    vecs[1] = '{"junk before sync", 128'h00_FF_5A_A5_01_00_EF_BE_AD_DE, 10, -1,
                1, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2] = '{"length overflow", 128'hA5_01_01, 3, -1,
                0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[3] = '{"framing error", 128'hA5_02_00_11_22_33_44_55_66, 9, 4,
                0, 32'h0, 32'h0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("power-on");

    for (int v = 0; v < 4; v++) begin
      load_bytes(vecs[v].bytes, vecs[v].nbytes, vecs[v].bad_idx);
      send_frame(1'b1);
      check({vecs[v].name, " writes"}, 64'(wr_data_q.size()), 64'(vecs[v].exp_writes));
      if (vecs[v].exp_writes > 0 && wr_data_q.size() > 0) begin
        check({vecs[v].name, " last addr"}, 64'(wr_addr_q[$]), 64'(vecs[v].exp_last_addr));
        check({vecs[v].name, " last data"}, 64'(wr_data_q[$]), 64'(vecs[v].exp_last_data));
      end
      check({vecs[v].name, " done"}, 64'(done), 64'(vecs[v].exp_done));
      check({vecs[v].name, " error"}, 64'(error), 64'(vecs[v].exp_error));
      check({vecs[v].name, " cpu_hold"}, 64'(cpu_hold), 64'(!vecs[v].exp_done));
      check({vecs[v].name, " word_count"}, 64'(word_count), 64'(vecs[v].exp_writes));
      if (vecs[v].exp_error && vecs[v].bad_idx < 0) begin
        // error must follow the length byte's stop sample, inside its stop bit
        check({vecs[v].name, " error latency window"},
              64'((err_cyc - stop_cyc >= 2) && (err_cyc - stop_cyc <= CPB)), 64'(1));
      end
      compare_model({vecs[v].name, " model"});
    end

    // Start-bit glitch: 3-cycle low pulse must be discarded.
    pulse_reset();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch no write", 64'(wr_data_q.size()), 64'(0));
    check("glitch no error", 64'({error, done, cpu_hold}), 64'(3'b001));
    load_bytes(128'hA5_01_00_EF_BE_AD_DE, 7, -1);
    send_frame(1'b0);
    check("post-glitch data", 64'(wr_data_q.size() > 0 ? wr_data_q[0] : 32'hX), 64'(32'hDEADBEEF));
    compare_model("post-glitch");

    // Reset after two data bytes of the first word.
    pulse_reset();
    load_bytes(128'hA5_01_00_78_56, 5, -1);
    foreach (tx_b[i]) send_byte(tx_b[i], 1'b0);
    pulse_reset();
    check_reset_outputs("mid-word reset");
    load_bytes(128'hA5_01_00_78_56_34_12, 7, -1);
    send_frame(1'b0);
    check("resend data", 64'(wr_data_q.size() > 0 ? wr_data_q[0] : 32'hX), 64'(32'h12345678));
    compare_model("resend");

    // Randomized frames: junk prefix, random length (incl. 0 and overflow),
    // trailing byte after the image, occasional bad stop bit.
    for (int it = 0; it < 8; it++) begin
      int          nj;
      int          r;
      logic [15:0] n16;
      logic [7:0]  b;
      tx_b.delete();
      tx_bad.delete();
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        tx_b.push_back(b);
      end
      tx_b.push_back(8'hA5);
      r = $urandom_range(0, 9);
      n16 = (r == 0) ? 16'd0 : (r == 1) ? 16'd300 : 16'($urandom_range(1, 3));
      tx_b.push_back(n16[7:0]);
      tx_b.push_back(n16[15:8]);
      if (n16 <= 16'(DEPTH))
        for (int j = 0; j < 4 * int'(n16); j++) tx_b.push_back(8'($urandom_range(0, 255)));
      tx_b.push_back(8'($urandom_range(0, 255)));
      foreach (tx_b[j]) tx_bad.push_back(1'b0);
      if ($urandom_range(0, 3) == 0) tx_bad[$urandom_range(0, tx_b.size() - 1)] = 1'b1;
      send_frame(1'b1);
      compare_model($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
